// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed position display scanner; DISP_SCAN_SKIP_EN scans only axes that have been strobed.
module disp_scan_ctrl #(
    parameter int NUM_AXES = 4,
    parameter int POS_W    = 10,
    parameter int DWELL    = 50000,
    parameter int BLANK    = 500,
    parameter int CENTER   = 540
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_AXES*POS_W-1:0] pos_bus,
    input  logic [NUM_AXES-1:0]       pos_valid,
    input  logic                      freeze,
    output logic [POS_W-1:0]          sel_pos,
    output logic [NUM_AXES-1:0]       digit_en,
    output logic [2:0]                cur_axis,
    output logic                      frame_done
);
    localparam int CW = $clog2(DWELL > BLANK ? DWELL : BLANK) + 1;
    typedef enum logic {S_BLANK, S_SHOW} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] axis_q, axis_d, nxt;
    logic wrap, snap;
    logic [POS_W-1:0] shadow_q [NUM_AXES];
    logic [POS_W-1:0] shadow_d [NUM_AXES];
    logic [POS_W-1:0] disp_q [NUM_AXES];
    logic [POS_W-1:0] disp_d [NUM_AXES];
    logic [POS_W-1:0] sel_q, sel_d;
    logic [NUM_AXES-1:0] en_q, en_d;
    logic fd_q, fd_d;
`ifdef DISP_SCAN_SKIP_EN
    logic [NUM_AXES-1:0] seen_q, seen_d;
    logic found;
    int idx;
`endif
    always_comb begin
`ifdef DISP_SCAN_SKIP_EN
        seen_d = seen_q | pos_valid;
        nxt = axis_q;
        wrap = 1'b0;
        found = 1'b0;
        idx = 0;
        for (int k = 1; k <= NUM_AXES; k++) begin
            idx = (int'(axis_q) + k) % NUM_AXES;
            if (!found && seen_q[idx]) begin
                found = 1'b1;
                nxt = 3'(idx);
                wrap = idx <= int'(axis_q);
            end
        end
`else
        wrap = axis_q == 3'(NUM_AXES - 1);
        nxt = wrap ? 3'd0 : axis_q + 3'd1;
`endif
        state_d = state_q;
        cnt_d = cnt_q + CW'(1);
        axis_d = axis_q;
        fd_d = 1'b0;
        snap = 1'b0;
        if (state_q == S_BLANK) begin
            if (cnt_q == CW'(BLANK - 1)) begin
                cnt_d = '0;
`ifdef DISP_SCAN_SKIP_EN
                // Idle in blank until some axis has reported; then start on the lowest seen one
                if (seen_q != '0) begin
                    state_d = S_SHOW;
                    axis_d = seen_q[axis_q] ? axis_q : nxt;
                end
`else
                state_d = S_SHOW;
`endif
            end
        end else if (cnt_q == CW'(DWELL - 1)) begin
            state_d = S_BLANK;
            cnt_d = '0;
            axis_d = nxt;
            fd_d = wrap;
            snap = wrap && !freeze;
        end
        for (int i = 0; i < NUM_AXES; i++) begin
            shadow_d[i] = pos_valid[i] ? pos_bus[i*POS_W +: POS_W] : shadow_q[i];
            disp_d[i] = snap ? shadow_q[i] : disp_q[i];
        end
        // Route from the next-state display so a fresh snapshot is visible on the same edge
        sel_d = disp_d[0];
        for (int i = 1; i < NUM_AXES; i++)
            sel_d = (axis_d == 3'(i)) ? disp_d[i] : sel_d;
        en_d = (state_d == S_SHOW) ? NUM_AXES'(1) << axis_d : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BLANK;
            cnt_q <= '0;
            axis_q <= '0;
            sel_q <= POS_W'(CENTER);
            en_q <= '0;
            fd_q <= 1'b0;
            for (int i = 0; i < NUM_AXES; i++) begin
                shadow_q[i] <= POS_W'(CENTER);
                disp_q[i] <= POS_W'(CENTER);
            end
`ifdef DISP_SCAN_SKIP_EN
            seen_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            axis_q <= axis_d;
            sel_q <= sel_d;
            en_q <= en_d;
            fd_q <= fd_d;
            for (int i = 0; i < NUM_AXES; i++) begin
                shadow_q[i] <= shadow_d[i];
                disp_q[i] <= disp_d[i];
            end
`ifdef DISP_SCAN_SKIP_EN
            seen_q <= seen_d;
`endif
        end
    end
    assign sel_pos = sel_q;
    assign digit_en = en_q;
    assign cur_axis = axis_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed checks of scan timing, snapshot, freeze and reset behaviour.
module tb_disp_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [39:0] pos_bus = '0;
    logic [3:0] pos_valid = '0;
    logic freeze = 1'b0;
    logic [9:0] sel_pos;
    logic [3:0] digit_en;
    logic [2:0] cur_axis;
    logic frame_done;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    disp_scan_ctrl #(.NUM_AXES(4), .POS_W(10), .DWELL(4), .BLANK(2), .CENTER(540)) dut (
        .clk(clk), .rst(rst), .pos_bus(pos_bus), .pos_valid(pos_valid), .freeze(freeze),
        .sel_pos(sel_pos), .digit_en(digit_en), .cur_axis(cur_axis), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic run_to(input int e);
        while (cyc < e) tick();
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask
    initial begin
        tick();
        cyc = 0;
        chk("rst_sel", 32'(sel_pos), 540);
        chk("rst_en", 32'(digit_en), 0);
        chk("rst_axis", 32'(cur_axis), 0);
        chk("rst_fd", 32'(frame_done), 0);
        rst = 1'b0;
`ifdef DISP_SCAN_SKIP_EN
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_en", 32'(digit_en), 0);
            chk("idle_fd", 32'(frame_done), 0);
            chk("idle_axis", 32'(cur_axis), 0);
        end
        pos_valid = 4'b1010;
        pos_bus = {10'd100, 10'd0, 10'd200, 10'd0};
        tick();
        pos_valid = '0;
        run_to(12);
        chk("skip_e12", 32'(digit_en), 4'b0010);
        run_to(15);
        chk("skip_e15", 32'(digit_en), 4'b0010);
        run_to(16);
        chk("skip_blank1", 32'(digit_en), 0);
        chk("skip_blank1_axis", 32'(cur_axis), 3);
        chk("skip_blank1_fd", 32'(frame_done), 0);
        run_to(17);
        chk("skip_blank1b", 32'(digit_en), 0);
        run_to(18);
        chk("skip_e18", 32'(digit_en), 4'b1000);
        run_to(22);
        chk("skip_wrap_fd", 32'(frame_done), 1);
        chk("skip_wrap_axis", 32'(cur_axis), 1);
        chk("skip_wrap_en", 32'(digit_en), 0);
        run_to(24);
        chk("skip_e24", 32'(digit_en), 4'b0010);
        chk("skip_e24_sel", 32'(sel_pos), 200);
        run_to(30);
        chk("skip_e30", 32'(digit_en), 4'b1000);
        chk("skip_e30_sel", 32'(sel_pos), 100);
`else
        pos_valid = 4'b0100;
        pos_bus = {10'd0, 10'd830, 10'd0, 10'd0};
        tick();
        pos_valid = '0;
        chk("e1_en", 32'(digit_en), 0);
        run_to(2);
        chk("e2_en", 32'(digit_en), 4'b0001);
        chk("e2_sel", 32'(sel_pos), 540);
        run_to(5);
        chk("e5_en", 32'(digit_en), 4'b0001);
        run_to(6);
        chk("e6_en", 32'(digit_en), 0);
        chk("e6_axis", 32'(cur_axis), 1);
        chk("e6_fd", 32'(frame_done), 0);
        run_to(8);
        chk("e8_en", 32'(digit_en), 4'b0010);
        run_to(14);
        chk("e14_en", 32'(digit_en), 4'b0100);
        chk("f0_axis2_sel", 32'(sel_pos), 540);
        run_to(20);
        chk("e20_en", 32'(digit_en), 4'b1000);
        run_to(23);
        chk("e23_fd", 32'(frame_done), 0);
        run_to(24);
        chk("wrap0_fd", 32'(frame_done), 1);
        chk("wrap0_en", 32'(digit_en), 0);
        chk("wrap0_axis", 32'(cur_axis), 0);
        run_to(25);
        chk("e25_fd", 32'(frame_done), 0);
        run_to(38);
        chk("f1_axis2_en", 32'(digit_en), 4'b0100);
        chk("f1_axis2_sel", 32'(sel_pos), 830);
        run_to(47);
        pos_valid = 4'b0010;
        pos_bus = {10'd0, 10'd0, 10'd300, 10'd0};
        run_to(48);
        pos_valid = '0;
        chk("wrap1_fd", 32'(frame_done), 1);
        run_to(56);
        chk("f2_axis1_en", 32'(digit_en), 4'b0010);
        chk("f2_axis1_sel", 32'(sel_pos), 540);
        run_to(80);
        chk("f3_axis1_sel", 32'(sel_pos), 300);
        pos_valid = 4'b0001;
        pos_bus = {10'd0, 10'd0, 10'd0, 10'd228};
        freeze = 1'b1;
        tick();
        pos_valid = '0;
        run_to(96);
        chk("frz_wrap_fd", 32'(frame_done), 1);
        run_to(98);
        chk("frz_axis0_en", 32'(digit_en), 4'b0001);
        chk("frz_axis0_sel", 32'(sel_pos), 540);
        freeze = 1'b0;
        run_to(110);
        chk("frz_axis2_sel", 32'(sel_pos), 830);
        run_to(120);
        chk("unfrz_wrap_fd", 32'(frame_done), 1);
        run_to(122);
        chk("unfrz_axis0_sel", 32'(sel_pos), 228);
        chk("unfrz_axis0_en", 32'(digit_en), 4'b0001);
        run_to(134);
        chk("pre_rst_en", 32'(digit_en), 4'b0100);
        chk("pre_rst_axis", 32'(cur_axis), 2);
        run_to(135);
        rst = 1'b1;
        run_to(136);
        rst = 1'b0;
        chk("mid_rst_sel", 32'(sel_pos), 540);
        chk("mid_rst_en", 32'(digit_en), 0);
        chk("mid_rst_axis", 32'(cur_axis), 0);
        chk("mid_rst_fd", 32'(frame_done), 0);
        run_to(137);
        chk("post_rst_blank", 32'(digit_en), 0);
        run_to(138);
        chk("post_rst_en", 32'(digit_en), 4'b0001);
        chk("post_rst_sel", 32'(sel_pos), 540);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
